// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control unit:
// opcode constants, FSM state encoding, datapath mux-select constants
// and the opcode -> immediate-format helper.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_out_decoder.sv
// Combinational Moore output decode: FSM state -> datapath control vector.
// Ports:
//   state      current FSM state
//   rdy        memory ready (already folded with the handshake enable)
//   adrsrc, memwrite, irwrite, regwrite, resultsrc, alusrca, alusrcb,
//   aluop      datapath controls
//   pcupdate   unconditional PC write term
//   branch     conditional PC write term (qualified by zero in the top)
module mc_ctrl_out_decoder
    import riscv_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       rdy,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       pcupdate,
    output logic       branch
);

    always_comb begin
        adrsrc    = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        regwrite  = 1'b0;
        resultsrc = RES_ALUOUT;
        alusrca   = SRCA_PC;
        alusrcb   = SRCB_RS2;
        aluop     = ALUOP_ADD;
        pcupdate  = 1'b0;
        branch    = 1'b0;
        case (state)
            S_FETCH: begin
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALURESULT;
                irwrite   = rdy;
                pcupdate  = rdy;
            end
            S_DECODE: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
            end
            S_MEMADR: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
            end
            S_MEMREAD: begin
                adrsrc = 1'b1;
            end
            S_MEMWB: begin
                resultsrc = RES_DATA;
                regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTER: begin
                alusrca = SRCA_RS1;
                aluop   = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
            end
            S_JAL: begin
                alusrca  = SRCA_OLDPC;
                alusrcb  = SRCB_FOUR;
                pcupdate = 1'b1;
            end
            S_BEQ: begin
                alusrca = SRCA_RS1;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RISC-V control unit (Moore FSM) for the shared-memory datapath.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   op           opcode from the instruction register
//   zero         ALU zero flag
//   mem_ready    memory access completes this cycle
//   pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc, alusrca,
//   alusrcb, aluop, immsrc   datapath controls
//   illegal      one-cycle pulse in DECODE for an unsupported opcode
//   instret      retired-instruction counter (wraps)
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int          MEM_HANDSHAKE = 1,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pcwrite,
    output logic             adrsrc,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regwrite,
    output logic [1:0]       resultsrc,
    output logic [1:0]       alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       aluop,
    output logic [2:0]       immsrc,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_t state, next_state;
    logic   rdy;
    logic   retire;
    logic   supported;
    logic   memwrite_raw, irwrite_raw, regwrite_raw;
    logic   pcupdate, branch;

    assign rdy    = mem_ready | (MEM_HANDSHAKE == 0);
    assign immsrc = imm_sel(op);

    always_comb begin
        case (op)
            OP_LW, OP_SW, OP_R, OP_IALU, OP_BEQ, OP_JAL: supported = 1'b1;
            default:                                     supported = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:    if (rdy) next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXECUTER;
                    OP_IALU:      next_state = S_EXECUTEI;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_JAL:       next_state = S_JAL;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (rdy) next_state = S_MEMWB;
            S_MEMWRITE: if (rdy) next_state = S_FETCH;
            S_MEMWB, S_BEQ, S_ALUWB:          next_state = S_FETCH;
            S_EXECUTER, S_EXECUTEI, S_JAL:    next_state = S_ALUWB;
            default:    next_state = S_FETCH;
        endcase
    end

    // Only completing instructions retire; the illegal path re-enters FETCH
    // from DECODE and is therefore excluded.
    assign retire = (next_state == S_FETCH) &&
                    (state inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      instret <= '0;
        else if (retire) instret <= instret + CNT_W'(1);
    end

    mc_ctrl_out_decoder u_dec (
        .state     (state),
        .rdy       (rdy),
        .adrsrc    (adrsrc),
        .memwrite  (memwrite_raw),
        .irwrite   (irwrite_raw),
        .regwrite  (regwrite_raw),
        .resultsrc (resultsrc),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .aluop     (aluop),
        .pcupdate  (pcupdate),
        .branch    (branch)
    );

    // Strobes are gated by rst_n so they drop the instant reset asserts,
    // independent of the state register's clock.
    assign pcwrite  = rst_n & (pcupdate | (branch & zero));
    assign memwrite = rst_n & memwrite_raw;
    assign irwrite  = rst_n & irwrite_raw;
    assign regwrite = rst_n & regwrite_raw;
    assign illegal  = rst_n & (state == S_DECODE) & ~supported;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

    typedef struct packed {
        logic        pcwrite;
        logic        adrsrc;
        logic        memwrite;
        logic        irwrite;
        logic        regwrite;
        logic [1:0]  resultsrc;
        logic [1:0]  alusrca;
        logic [1:0]  alusrcb;
        logic [1:0]  aluop;
        logic [2:0]  immsrc;
        logic        illegal;
        logic [31:0] instret;
    } ctl_t;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IALU = 7'b0010011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] BAD  = 7'b1111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: handshake enabled
    logic        rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic [6:0]  op = 7'd0;
    logic        pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
    logic [1:0]  resultsrc, alusrca, alusrcb, aluop;
    logic [2:0]  immsrc;
    logic [31:0] instret;

    // DUT B: handshake disabled, mem_ready tied low
    logic        rst_n_b = 1'b0, zero_b = 1'b0;
    logic [6:0]  op_b = 7'd0;
    logic        pcwrite_b, adrsrc_b, memwrite_b, irwrite_b, regwrite_b, illegal_b;
    logic [1:0]  resultsrc_b, alusrca_b, alusrcb_b, aluop_b;
    logic [2:0]  immsrc_b;
    logic [31:0] instret_b;

    multicycle_ctrl_fsm #(.MEM_HANDSHAKE(1), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .adrsrc(adrsrc), .memwrite(memwrite), .irwrite(irwrite),
        .regwrite(regwrite), .resultsrc(resultsrc), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluop(aluop), .immsrc(immsrc), .illegal(illegal),
        .instret(instret)
    );

    multicycle_ctrl_fsm #(.MEM_HANDSHAKE(0), .CNT_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .op(op_b), .zero(zero_b), .mem_ready(1'b0),
        .pcwrite(pcwrite_b), .adrsrc(adrsrc_b), .memwrite(memwrite_b), .irwrite(irwrite_b),
        .regwrite(regwrite_b), .resultsrc(resultsrc_b), .alusrca(alusrca_b),
        .alusrcb(alusrcb_b), .aluop(aluop_b), .immsrc(immsrc_b), .illegal(illegal_b),
        .instret(instret_b)
    );

    ctl_t  q_a[$], q_b[$];
    string n_a[$], n_b[$];
    int    checks = 0;
    int    fails  = 0;

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            SW:      return 3'b001;
            BEQ:     return 3'b010;
            JAL:     return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    // Expected control vector for a named state, straight from the state table.
    function automatic ctl_t mk(input string st, input logic [6:0] o, input logic rdy,
                                input logic z, input logic [31:0] cnt);
        ctl_t e;
        e = '0;
        e.immsrc  = imm_of(o);
        e.instret = cnt;
        case (st)
            "RESET":    begin e.alusrcb = 2'b10; e.resultsrc = 2'b10; end
            "FETCH":    begin e.alusrcb = 2'b10; e.resultsrc = 2'b10;
                              e.irwrite = rdy; e.pcwrite = rdy; end
            "DECODE":   begin e.alusrca = 2'b01; e.alusrcb = 2'b01;
                              e.illegal = (o == BAD); end
            "MEMADR":   begin e.alusrca = 2'b10; e.alusrcb = 2'b01; end
            "MEMREAD":  begin e.adrsrc = 1'b1; end
            "MEMWB":    begin e.resultsrc = 2'b01; e.regwrite = 1'b1; end
            "MEMWRITE": begin e.adrsrc = 1'b1; e.memwrite = 1'b1; end
            "EXECUTER": begin e.alusrca = 2'b10; e.aluop = 2'b10; end
            "EXECUTEI": begin e.alusrca = 2'b10; e.alusrcb = 2'b01; e.aluop = 2'b10; end
            "ALUWB":    begin e.regwrite = 1'b1; end
            "JAL":      begin e.alusrca = 2'b01; e.alusrcb = 2'b10; e.pcwrite = 1'b1; end
            "BEQ":      begin e.alusrca = 2'b10; e.aluop = 2'b01; e.pcwrite = z; end
            default:    e = '1;
        endcase
        return e;
    endfunction

    // One stimulus cycle: drive inputs just after the edge, queue the expectation.
    task automatic cyc(input bit b, input string st, input logic [6:0] o,
                       input logic mr, input logic z, input logic rst, input logic [31:0] cnt);
        @(posedge clk);
        #1;
        if (!b) begin
            op = o; mem_ready = mr; zero = z; rst_n = rst;
            q_a.push_back(mk(st, o, mr, z, cnt));
            n_a.push_back(st);
        end else begin
            op_b = o; zero_b = z; rst_n_b = rst;
            q_b.push_back(mk(st, o, 1'b1, z, cnt));
            n_b.push_back(st);
        end
    endtask

    // Monitor: compares DUT outputs against queued expectations on the falling edge.
    always @(negedge clk) begin
        ctl_t  e, a;
        string nm;
        if (q_a.size() > 0) begin
            e  = q_a.pop_front();
            nm = n_a.pop_front();
            a  = '{pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc, alusrca,
                   alusrcb, aluop, immsrc, illegal, instret};
            checks++;
            if (a !== e) begin
                fails++;
                $display("FAIL A/%s @%0t: got %h expected %h", nm, $time, a, e);
            end
        end
        if (q_b.size() > 0) begin
            e  = q_b.pop_front();
            nm = n_b.pop_front();
            a  = '{pcwrite_b, adrsrc_b, memwrite_b, irwrite_b, regwrite_b, resultsrc_b,
                   alusrca_b, alusrcb_b, aluop_b, immsrc_b, illegal_b, instret_b};
            checks++;
            if (a !== e) begin
                fails++;
                $display("FAIL B/%s @%0t: got %h expected %h", nm, $time, a, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        cyc(0, "RESET", LW, 1, 0, 0, 0);
        cyc(0, "RESET", LW, 1, 0, 0, 0);
        // LW, no stalls
        cyc(0, "FETCH",   LW, 1, 0, 1, 0);
        cyc(0, "DECODE",  LW, 1, 0, 1, 0);
        cyc(0, "MEMADR",  LW, 1, 0, 1, 0);
        cyc(0, "MEMREAD", LW, 1, 0, 1, 0);
        cyc(0, "MEMWB",   LW, 1, 0, 1, 0);
        // SW, two stall cycles in MEMWRITE
        cyc(0, "FETCH",    SW, 1, 0, 1, 1);
        cyc(0, "DECODE",   SW, 1, 0, 1, 1);
        cyc(0, "MEMADR",   SW, 1, 0, 1, 1);
        cyc(0, "MEMWRITE", SW, 0, 0, 1, 1);
        cyc(0, "MEMWRITE", SW, 0, 0, 1, 1);
        cyc(0, "MEMWRITE", SW, 1, 0, 1, 1);
        // BEQ taken
        cyc(0, "FETCH",  BEQ, 1, 0, 1, 2);
        cyc(0, "DECODE", BEQ, 1, 0, 1, 2);
        cyc(0, "BEQ",    BEQ, 1, 1, 1, 2);
        // BEQ not taken, with a fetch stall first
        cyc(0, "FETCH",  BEQ, 0, 0, 1, 3);
        cyc(0, "FETCH",  BEQ, 1, 0, 1, 3);
        cyc(0, "DECODE", BEQ, 1, 0, 1, 3);
        cyc(0, "BEQ",    BEQ, 1, 0, 1, 3);
        // JAL
        cyc(0, "FETCH",  JAL, 1, 0, 1, 4);
        cyc(0, "DECODE", JAL, 1, 0, 1, 4);
        cyc(0, "JAL",    JAL, 1, 0, 1, 4);
        cyc(0, "ALUWB",  JAL, 1, 0, 1, 4);
        // I-ALU
        cyc(0, "FETCH",    IALU, 1, 0, 1, 5);
        cyc(0, "DECODE",   IALU, 1, 0, 1, 5);
        cyc(0, "EXECUTEI", IALU, 1, 0, 1, 5);
        cyc(0, "ALUWB",    IALU, 1, 0, 1, 5);
        // R-type
        cyc(0, "FETCH",    RT, 1, 0, 1, 6);
        cyc(0, "DECODE",   RT, 1, 0, 1, 6);
        cyc(0, "EXECUTER", RT, 1, 0, 1, 6);
        cyc(0, "ALUWB",    RT, 1, 0, 1, 6);
        // LW with op changing after MEMADR: path unaffected
        cyc(0, "FETCH",   LW, 1, 0, 1, 7);
        cyc(0, "DECODE",  LW, 1, 0, 1, 7);
        cyc(0, "MEMADR",  LW, 1, 0, 1, 7);
        cyc(0, "MEMREAD", SW, 1, 0, 1, 7);
        cyc(0, "MEMWB",   JAL, 1, 0, 1, 7);
        // illegal opcode: pulse in DECODE, back to FETCH, no retire
        cyc(0, "FETCH",  BAD, 1, 0, 1, 8);
        cyc(0, "DECODE", BAD, 1, 0, 1, 8);
        cyc(0, "FETCH",  BAD, 0, 0, 1, 8);
        // reset asserted mid-MEMWRITE
        cyc(0, "FETCH",    SW, 1, 0, 1, 8);
        cyc(0, "DECODE",   SW, 1, 0, 1, 8);
        cyc(0, "MEMADR",   SW, 1, 0, 1, 8);
        cyc(0, "MEMWRITE", SW, 0, 0, 1, 8);
        cyc(0, "RESET",    SW, 0, 0, 0, 0);
        cyc(0, "RESET",    SW, 1, 0, 0, 0);
        cyc(0, "FETCH",    SW, 1, 0, 1, 0);

        // DUT B: handshake off, mem_ready tied 0
        cyc(1, "RESET",    RT, 0, 0, 0, 0);
        cyc(1, "FETCH",    RT, 0, 0, 1, 0);
        cyc(1, "DECODE",   RT, 0, 0, 1, 0);
        cyc(1, "EXECUTER", RT, 0, 0, 1, 0);
        cyc(1, "ALUWB",    RT, 0, 0, 1, 0);
        cyc(1, "FETCH",    SW, 0, 0, 1, 1);
        cyc(1, "DECODE",   SW, 0, 0, 1, 1);
        cyc(1, "MEMADR",   SW, 0, 0, 1, 1);
        cyc(1, "MEMWRITE", SW, 0, 0, 1, 1);
        cyc(1, "FETCH",    LW, 0, 0, 1, 2);

        for (int i = 0; i < 10 && (q_a.size() + q_b.size()) > 0; i++) @(posedge clk);
        @(posedge clk);
        if ((q_a.size() + q_b.size()) > 0) begin
            checks++;
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", q_a.size() + q_b.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Multicycle RISC-V control unit. It is the sequential successor of the single-cycle main decoder and drives the shared-memory multicycle datapath. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback. It adds I-type ALU and JAL support, a memory-ready stall handshake, illegal-opcode flagging and a retired-instruction counter.

Parameters:
MEM_HANDSHAKE, 1, 1: FETCH/MEMREAD/MEMWRITE wait for mem_ready. 0: mem_ready is ignored and treated as 1.
CNT_W, 32, width of the instret counter.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
op  in  7  opcode field from the instruction register.
zero  in  1  ALU zero flag.
mem_ready  in  1  memory access complete in this cycle.
pcwrite  out  1  PC register enable.
adrsrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
memwrite  out  1  data memory write strobe.
irwrite  out  1  instruction register enable.
regwrite  out  1  register file write enable.
resultsrc  out  2  result mux: 00 ALUOut, 01 Data, 10 ALUResult.
alusrca  out  2  ALU A mux: 00 PC, 01 OldPC, 10 rs1.
alusrcb  out  2  ALU B mux: 00 rs2, 01 Imm, 10 const 4.
aluop  out  2  to the ALU decoder: 00 add, 01 sub, 10 funct-decoded.
immsrc  out  3  immediate format: 000 I, 001 S, 010 B, 011 J.
illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode.
instret  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (rst_n low, asynchronous): state = FETCH, instret = 0. pcwrite, irwrite, memwrite, regwrite and illegal are forced to 0 while rst_n is low. Mux-select outputs take their FETCH values.
- Supported opcodes: LW 0000011, SW 0100011, R 0110011, I-ALU 0010011, BEQ 1100011, JAL 1101111.
- immsrc is combinational from op:
  - LW and I-ALU: 000.
  - SW: 001.
  - BEQ: 010.
  - JAL: 011.
  - All other opcodes: 000.
- pcwrite = pcupdate | (branch & zero). pcupdate and branch are internal state-decoded terms.
- Per-state outputs. Any signal not listed is 0 / 00.
  - FETCH: adrsrc 0, alusrca 00, alusrcb 10, resultsrc 10, aluop 00. irwrite = pcupdate = rdy, where rdy = mem_ready | ~MEM_HANDSHAKE.
  - DECODE: alusrca 01, alusrcb 01, aluop 00. This computes the branch/jump target into ALUOut.
  - MEMADR: alusrca 10, alusrcb 01, aluop 00.
  - MEMREAD: adrsrc 1, resultsrc 00.
  - MEMWB: resultsrc 01, regwrite 1.
  - MEMWRITE: adrsrc 1, resultsrc 00, memwrite 1. memwrite is held high until rdy.
  - EXECUTER: alusrca 10, alusrcb 00, aluop 10.
  - EXECUTEI: alusrca 10, alusrcb 01, aluop 10.
  - ALUWB: resultsrc 00, regwrite 1.
  - JAL: alusrca 01, alusrcb 10, resultsrc 00, pcupdate 1.
  - BEQ: alusrca 10, alusrcb 00, aluop 01, resultsrc 00, branch 1.
- Transitions:
  - FETCH: to DECODE if rdy, else stay in FETCH.
  - DECODE by opcode:
    - LW or SW: MEMADR.
    - R: EXECUTER.
    - I-ALU: EXECUTEI.
    - BEQ: BEQ.
    - JAL: JAL.
    - Any other opcode: illegal = 1 and go to FETCH.
  - MEMADR: to MEMREAD for LW, to MEMWRITE for SW.
  - MEMREAD: to MEMWB if rdy, else stay.
  - MEMWRITE: to FETCH if rdy, else stay.
  - MEMWB, BEQ and ALUWB: to FETCH.
  - EXECUTER and EXECUTEI: to ALUWB.
  - JAL: to ALUWB.
- Latency in cycles with no stalls: LW 5, SW 4, R 4, I-ALU 4, JAL 4, BEQ 3. Each stall cycle adds 1.
- instret increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. It does not increment on the illegal path and wraps modulo 2^CNT_W.
- op is sampled in DECODE and MEMADR only. op changes in other states are ignored.
- Reset mid-operation forces FETCH immediately. No pending write strobe survives the reset.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants;
  - state encoding (4-bit, 11 states);
  - resultsrc / alusrca / alusrcb / aluop / immsrc select constants.
- One sub-module, mc_ctrl_out_decoder: combinational state -> control-vector decode. The FSM top holds the state register, next-state logic and instret.

Test Plan:
- LW, MEM_HANDSHAKE=1, mem_ready held 1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB over 5 cycles. regwrite=1 and resultsrc=01 in cycle 5. instret goes 0 -> 1.
- SW with mem_ready low for 2 cycles in MEMWRITE -> memwrite high for exactly 3 cycles, no regwrite, instret +1 on exit.
- BEQ with zero=1 -> pcwrite=1 in the BEQ cycle, aluop=01, immsrc=010. Repeat with zero=0 -> pcwrite=0. Both complete in 3 cycles.
- JAL -> pcwrite=1 in the JAL state, then ALUWB with regwrite=1. immsrc=011, 4 cycles total.
- op=1111111 -> illegal pulses for 1 cycle in DECODE, next state FETCH, instret unchanged.
- rst_n driven low during MEMWRITE -> memwrite and regwrite drop to 0 asynchronously, instret=0, FETCH on release. With MEM_HANDSHAKE=0 and mem_ready tied 0, R-type still completes in 4 cycles.
